// File: rtl/adc_capture_buffer_if.sv
// Sample stream from the capture buffer to its consumer.
//   m_data  : captured sample, two's complement
//   m_valid : m_data holds a sample
//   m_ready : consumer accepts m_data this cycle
//   m_last  : marks the final sample of a capture
// Modports: master (buffer side), slave (consumer side).
interface adc_capture_buffer_if;
  logic [13:0] m_data;
  logic        m_valid;
  logic        m_ready;
  logic        m_last;

  modport master (output m_data, output m_valid, output m_last, input m_ready);
  modport slave  (input m_data, input m_valid, input m_last, output m_ready);
endinterface

// File: rtl/adc_capture_buffer.sv
// Triggered ADC capture buffer. Registers every ADC word (offset-binary converted to two's
// complement), waits for a rising threshold crossing or a forced trigger, stores DEPTH
// consecutive samples and streams them out in address order.
// Ports:
//   clk, reset_n        : sample clock, synchronous active-low reset
//   adc_data, adc_otr   : raw ADC word and its out-of-range flag
//   arm, force_trig     : start a capture / trigger unconditionally while armed
//   trig_level          : signed trigger threshold
//   state_o             : 0 idle, 1 armed, 2 capture, 3 readout
//   ovr_flag            : sticky, a stored sample was out of range
//   done                : one-cycle pulse after the last sample is accepted
//   m                   : sample stream (master side)
module adc_capture_buffer #(
  parameter int unsigned DEPTH  = 1024,
  parameter int unsigned ADDR_W = 10
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic [13:0]                  adc_data,
  input  logic                         adc_otr,
  input  logic                         arm,
  input  logic                         force_trig,
  input  logic [13:0]                  trig_level,
  output logic [1:0]                   state_o,
  output logic                         ovr_flag,
  output logic                         done,
  adc_capture_buffer_if.master         m
);

  typedef enum logic [1:0] {StIdle = 2'd0, StArmed = 2'd1, StCapture = 2'd2, StReadout = 2'd3}
    state_e;

  localparam logic [ADDR_W-1:0] LastAddr = ADDR_W'(DEPTH - 1);

  state_e state_q, state_d;

  logic [13:0]       s_q, prev_q, ram_q;
  logic              otr_q, first_q, ovr_q, done_q;
  logic [ADDR_W-1:0] wr_addr_q, rd_addr_q;
  logic              rd_all_q, rd_pend_q, rd_last_q;
  logic [13:0]       out_data_q, sk_data_q;
  logic              out_valid_q, out_last_q, sk_valid_q, sk_last_q;

  logic [13:0] mem [DEPTH];

  logic       trig, we, pop, push, issue, finish;
  logic [1:0] occ_after;

  // The first sample seen while armed only seeds prev; no trigger can fire on it.
  assign trig = (state_q == StArmed) && !first_q &&
                ((($signed(prev_q) < $signed(trig_level)) &&
                  ($signed(s_q) >= $signed(trig_level))) || force_trig);
  assign we   = trig || (state_q == StCapture);

  // Output register plus one skid entry; a read is issued only if its data will have a slot.
  assign pop       = out_valid_q && m.m_ready;
  assign push      = rd_pend_q;
  assign finish    = pop && out_last_q;
  assign occ_after = 2'(out_valid_q) + 2'(sk_valid_q) + 2'(rd_pend_q) - 2'(pop);
  assign issue     = (state_q == StReadout) && !rd_all_q && (occ_after < 2'd2);

  always_ff @(posedge clk) begin : p_state
    if (!reset_n) state_q <= StIdle;
    else          state_q <= state_d;
  end

  always_comb begin : p_next
    state_d = state_q;
    unique case (state_q)
      StIdle:    if (arm) state_d = StArmed;
      StArmed:   if (trig) state_d = StCapture;
      StCapture: if (wr_addr_q == LastAddr) state_d = StReadout;
      StReadout: if (finish) state_d = StIdle;
      default:   state_d = StIdle;
    endcase
  end

  always_comb begin : p_out
    state_o   = state_q;
    m.m_data  = out_data_q;
    m.m_valid = out_valid_q;
    m.m_last  = out_last_q;
    ovr_flag  = ovr_q;
    done      = done_q;
  end

  // Sample memory has no reset; stale contents are never read before being rewritten.
  always_ff @(posedge clk) begin : p_ram
    if (we) mem[wr_addr_q] <= s_q;
    ram_q <= mem[rd_addr_q];
  end

  always_ff @(posedge clk) begin : p_data
    if (!reset_n) begin
      s_q         <= '0;
      otr_q       <= 1'b0;
      prev_q      <= '0;
      first_q     <= 1'b1;
      ovr_q       <= 1'b0;
      done_q      <= 1'b0;
      wr_addr_q   <= '0;
      rd_addr_q   <= '0;
      rd_all_q    <= 1'b0;
      rd_pend_q   <= 1'b0;
      rd_last_q   <= 1'b0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      sk_data_q   <= '0;
      sk_valid_q  <= 1'b0;
      sk_last_q   <= 1'b0;
    end else begin
      s_q    <= {~adc_data[13], adc_data[12:0]};
      otr_q  <= adc_otr;
      done_q <= finish;

      unique case (state_q)
        StIdle: begin
          wr_addr_q <= '0;
          rd_addr_q <= '0;
          rd_all_q  <= 1'b0;
          first_q   <= 1'b1;
          if (arm) ovr_q <= 1'b0;
        end
        StArmed: begin
          first_q <= 1'b0;
          prev_q  <= s_q;
          if (trig) begin
            ovr_q     <= ovr_q | otr_q;
            wr_addr_q <= wr_addr_q + 1'b1;
          end
        end
        StCapture: begin
          ovr_q     <= ovr_q | otr_q;
          wr_addr_q <= wr_addr_q + 1'b1;
        end
        StReadout: begin
          if (issue) begin
            rd_addr_q <= rd_addr_q + 1'b1;
            if (rd_addr_q == LastAddr) rd_all_q <= 1'b1;
          end
        end
        default: ;
      endcase

      rd_pend_q <= issue;
      rd_last_q <= issue && (rd_addr_q == LastAddr);

      if (finish) begin
        out_valid_q <= 1'b0;
        out_last_q  <= 1'b0;
        sk_valid_q  <= 1'b0;
        sk_last_q   <= 1'b0;
      end else if (pop) begin
        if (sk_valid_q) begin
          out_data_q  <= sk_data_q;
          out_last_q  <= sk_last_q;
          out_valid_q <= 1'b1;
          sk_valid_q  <= push;
          sk_data_q   <= ram_q;
          sk_last_q   <= push && rd_last_q;
        end else begin
          out_valid_q <= push;
          out_last_q  <= push && rd_last_q;
          if (push) out_data_q <= ram_q;
        end
      end else if (push) begin
        if (!out_valid_q) begin
          out_data_q  <= ram_q;
          out_valid_q <= 1'b1;
          out_last_q  <= rd_last_q;
        end else begin
          sk_data_q  <= ram_q;
          sk_valid_q <= 1'b1;
          sk_last_q  <= rd_last_q;
        end
      end
    end
  end

endmodule

// File: tb/tb_adc_capture_buffer.sv
module tb_adc_capture_buffer;

  localparam int DEPTH = 16;
  localparam int N     = 96;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [13:0] adc_data;
  logic        adc_otr, arm, force_trig;
  logic [13:0] trig_level;
  logic [1:0]  state_o;
  logic        ovr_flag, done;

  adc_capture_buffer_if bus ();

  adc_capture_buffer #(.DEPTH(DEPTH), .ADDR_W(4)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .adc_data   (adc_data),
    .adc_otr    (adc_otr),
    .arm        (arm),
    .force_trig (force_trig),
    .trig_level (trig_level),
    .state_o    (state_o),
    .ovr_flag   (ovr_flag),
    .done       (done),
    .m          (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Input script indexed by cycle after the arm edge (index 0 is driven together with arm).
  logic [13:0] x_raw [N];
  logic        x_otr [N];
  logic        x_frc [N];
  logic [13:0] got_q [$];

  function automatic int sval(input logic [13:0] raw);
    return int'(raw) - 8192;
  endfunction

  // Sample driven at index i-1 is judged at edge i against the one before it; force at edge i.
  function automatic int find_trigger();
    int lvl;
    lvl = int'($signed(trig_level));
    for (int i = 2; i <= N - DEPTH; i++) begin
      if ((sval(x_raw[i-2]) < lvl && sval(x_raw[i-1]) >= lvl) || x_frc[i]) return i;
    end
    return -1;
  endfunction

  task automatic clear_script();
    for (int i = 0; i < N; i++) begin
      x_raw[i] = '0;
      x_otr[i] = 1'b0;
      x_frc[i] = 1'b0;
    end
  endtask

  task automatic random_script();
    for (int i = 0; i < N; i++) begin
      x_raw[i] = 14'($urandom_range(0, 16383));
      x_otr[i] = 1'b0;
      x_frc[i] = 1'b0;
    end
    trig_level = 14'($urandom_range(0, 16383));
    if ($urandom_range(0, 1) == 1) x_frc[$urandom_range(2, 70)] = 1'b1;
    if (find_trigger() < 0) x_frc[60] = 1'b1;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      arm        = 1'b0;
      force_trig = 1'b0;
      adc_otr    = 1'b0;
    end
  endtask

  // rmode 0: m_ready held high, otherwise random.
  task automatic run_capture(input int rmode, input bit arm_noise);
    logic [13:0] exp_q [$];
    logic        exp_ovr, got_last, pv, pr, pl;
    logic [13:0] pd;
    int ti, n, last_k, first_v, first_x;
    ti = find_trigger();
    exp_ovr = 1'b0;
    for (int j = 0; j < DEPTH; j++) begin
      exp_q.push_back(14'(sval(x_raw[ti-1+j])));
      exp_ovr |= x_otr[ti-1+j];
    end
    got_q.delete();
    n = 0; last_k = -10; first_v = -1; first_x = -1;
    got_last = 1'b0; pv = 1'b0; pr = 1'b0; pl = 1'b0; pd = '0;
    for (int k = 0; k < 300; k++) begin
      @(negedge clk);
      if (k == 1) begin
        check_eq("armed_state", 32'(state_o), 32'd1);
        check_eq("ovr_clear_on_arm", 32'(ovr_flag), 32'd0);
      end
      if (k == ti + 1) check_eq("capture_state", 32'(state_o), 32'd2);
      if (k == ti + 16) check_eq("readout_state", 32'(state_o), 32'd3);
      if (got_last && k == last_k + 1) begin
        check_eq("done_pulse", 32'(done), 32'd1);
        check_eq("valid_drop", 32'(bus.m_valid), 32'd0);
        check_eq("idle_after", 32'(state_o), 32'd0);
        check_eq("ovr_flag", 32'(ovr_flag), 32'(exp_ovr));
      end
      if (got_last && k == last_k + 2) begin
        check_eq("done_one_cycle", 32'(done), 32'd0);
        check_eq("ovr_sticky", 32'(ovr_flag), 32'(exp_ovr));
        break;
      end
      if (state_o != 2'd3 && bus.m_valid) check_eq("valid_outside_readout", 32'd1, 32'd0);
      if (pv && !pr)
        check_eq("stall_hold", {16'd0, bus.m_valid, bus.m_last, bus.m_data},
                 {16'd0, 1'b1, pl, pd});
      if (bus.m_valid && first_v < 0) first_v = k;
      arm        = (k == 0) ? 1'b1 : (arm_noise && !got_last && $urandom_range(0, 3) == 0);
      adc_data   = (k < N) ? x_raw[k] : 14'd0;
      adc_otr    = (k < N) ? x_otr[k] : 1'b0;
      force_trig = (k < N) ? x_frc[k] : 1'b0;
      bus.m_ready = (rmode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
      if (bus.m_valid && bus.m_ready && !got_last) begin
        if (first_x < 0) first_x = k;
        got_q.push_back(bus.m_data);
        if (n < DEPTH) check_eq($sformatf("data[%0d]", n), 32'(bus.m_data), 32'(exp_q[n]));
        else check_eq("extra_transfer", 32'(n), 32'(DEPTH - 1));
        check_eq($sformatf("last[%0d]", n), 32'(bus.m_last), 32'(n == DEPTH - 1));
        if (bus.m_last) begin
          got_last = 1'b1;
          last_k   = k;
        end
        n++;
      end
      pv = bus.m_valid; pr = bus.m_ready; pl = bus.m_last; pd = bus.m_data;
    end
    if (!got_last) check_eq("timeout_no_last", 32'd0, 32'd1);
    check_eq("count", 32'(n), 32'(DEPTH));
    check_eq("first_valid_latency", 32'(first_v >= 0 && first_v - (ti + 16) <= 3), 32'd1);
    if (rmode == 0) check_eq("no_bubbles", 32'(last_k - first_x), 32'(DEPTH - 1));
    arm = 1'b0; force_trig = 1'b0; adc_otr = 1'b0; bus.m_ready = 1'b0;
    idle(3);
  endtask

  initial begin
    int ti;
    reset_n = 1'b0; arm = 1'b0; force_trig = 1'b0; adc_otr = 1'b0;
    adc_data = '0; trig_level = '0; bus.m_ready = 1'b0;
    repeat (2) @(negedge clk);
    check_eq("rst_state", 32'(state_o), 32'd0);
    check_eq("rst_valid", 32'(bus.m_valid), 32'd0);
    check_eq("rst_last", 32'(bus.m_last), 32'd0);
    check_eq("rst_done", 32'(done), 32'd0);
    check_eq("rst_ovr", 32'(ovr_flag), 32'd0);
    check_eq("rst_data", 32'(bus.m_data), 32'd0);
    reset_n = 1'b1;
    idle(2);

    // Ramp through zero crossing.
    clear_script();
    trig_level = 14'd0;
    for (int i = 0; i < N; i++) x_raw[i] = 14'(14'h1FF0 + i);
    run_capture(0, 1'b0);
    if (got_q.size() == DEPTH) begin
      check_eq("ramp_first", 32'(got_q[0]), 32'h0000);
      check_eq("ramp_last", 32'(got_q[DEPTH-1]), 32'h000F);
    end else check_eq("ramp_size", 32'(got_q.size()), 32'(DEPTH));

    // Constant minimum code, forced trigger.
    clear_script();
    trig_level = 14'h1FFF;
    x_frc[5] = 1'b1;
    run_capture(1, 1'b0);
    if (got_q.size() == DEPTH) begin
      check_eq("force_first", 32'(got_q[0]), 32'h2000);
      check_eq("force_last", 32'(got_q[DEPTH-1]), 32'h2000);
    end else check_eq("force_size", 32'(got_q.size()), 32'(DEPTH));

    // Out-of-range inside the window.
    random_script();
    ti = find_trigger();
    x_otr[ti + 3] = 1'b1;
    run_capture(1, 1'b1);
    idle(2);
    check_eq("ovr_held_idle", 32'(ovr_flag), 32'd1);

    // Out-of-range only outside the window.
    random_script();
    ti = find_trigger();
    x_otr[ti - 2]  = 1'b1;
    x_otr[ti + 15] = 1'b1;
    run_capture(1, 1'b1);

    // Reset in the middle of a capture.
    clear_script();
    trig_level = 14'd0;
    for (int i = 0; i < N; i++) x_raw[i] = 14'h1000;
    x_frc[2] = 1'b1;
    for (int k = 0; k <= 10; k++) begin
      @(negedge clk);
      if (k == 9) check_eq("pre_reset_capture", 32'(state_o), 32'd2);
      if (k == 10) begin
        check_eq("mid_reset_state", 32'(state_o), 32'd0);
        check_eq("mid_reset_valid", 32'(bus.m_valid), 32'd0);
      end
      arm         = (k == 0);
      adc_data    = x_raw[k];
      force_trig  = x_frc[k];
      reset_n     = (k == 9) ? 1'b0 : 1'b1;
      bus.m_ready = 1'b1;
    end
    idle(3);
    random_script();
    run_capture(0, 1'b0);

    // Randomized captures with spurious arm pulses.
    for (int r = 0; r < 4; r++) begin
      random_script();
      if ($urandom_range(0, 1) == 1) x_otr[$urandom_range(0, N - 1)] = 1'b1;
      run_capture(r % 2, 1'b1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
